trap_ctrl: RTL

//  Trap arbiter between the MEM stage and the CSR file. Synchronises the external interrupt line and

---
 rtl/trap_ctrl_if.sv | 32 +++
 rtl/trap_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// Bus between trap_ctrl and its neighbours (MEM stage and CSR file).
//   master : pipeline/CSR side. Drives the MEM-stage instruction info and the CSR
//            values, and receives the trap strobe, flush and redirect PC.
//   slave  : trap_ctrl side.
interface trap_ctrl_if;
  logic        mem_valid_i;
  logic        stall_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_ecall_i;
  logic        mem_illegal_i;
  logic        mem_mret_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output mem_valid_i, stall_i, mem_inst_addr_i, mem_ecall_i, mem_illegal_i,
           mem_mret_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    input  excepttype_o, current_inst_addr_o, flush_o, new_pc_o
  );

  modport slave (
    input  mem_valid_i, stall_i, mem_inst_addr_i, mem_ecall_i, mem_illegal_i,
           mem_mret_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    output excepttype_o, current_inst_addr_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap arbiter between the MEM stage and the CSR file.
//   clk, rst     : clock, asynchronous active-low reset
//   ext_int_i    : external interrupt (asynchronous level, synchronised here)
//   timer_int_i  : timer interrupt level from the CSR file
//   bus (slave)  : MEM-stage instruction info, CSR values in;
//                  excepttype/current_inst_addr strobe, flush pulse, redirect PC out.
// A trap is committed in IDLE, presented for exactly one cycle in TRAP, and
// followed by one RECOVER cycle that blocks re-entry while the CSR file applies
// its MIE/mepc update.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned EXT_INT_CAUSE   = 11,
  parameter int unsigned TIMER_INT_CAUSE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_int_i,
  input  logic        timer_int_i,
  trap_ctrl_if.slave  bus
);

  localparam logic [3:0]  EXT_C   = 4'(EXT_INT_CAUSE);
  localparam logic [3:0]  TIMER_C = 4'(TIMER_INT_CAUSE);
  localparam logic [31:0] CODE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CODE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CODE_MRET    = 32'h0000_000A;
  localparam logic [31:0] CODE_EXT     = {1'b1, 27'b0, EXT_C};
  localparam logic [31:0] CODE_TIMER   = {1'b1, 27'b0, TIMER_C};

  typedef enum logic [1:0] {IDLE, TRAP, RECOVER} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   ext_pend_q, ext_pend_d;
  logic [31:0]            excepttype_q, excepttype_d;
  logic [31:0]            cia_q, cia_d;
  logic                   flush_q, flush_d;
  logic                   mret_q, mret_d;

  logic        ext_sync, ext_rise, mie_en, ext_ok, timer_ok, take, ext_commit;
  logic [31:0] code, base, new_pc;

  // Only MIE, MEIE and MTIE are consumed.
  logic unused_csr_bits;
  assign unused_csr_bits = ^{bus.mstatus_i[31:4], bus.mstatus_i[2:0],
                             bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:0]};

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], ext_int_i};
    ext_sync    = sync_q[SYNC_STAGES-1];
    sync_prev_d = ext_sync;
    ext_rise    = ext_sync & ~sync_prev_q;

    mie_en   = bus.mstatus_i[3];
    ext_ok   = ext_pend_q & mie_en & bus.mie_i[11];
    timer_ok = timer_int_i & mie_en & bus.mie_i[7];
    take     = bus.mem_valid_i & ~bus.stall_i & (state_q == IDLE);

    // Priority: synchronous exceptions first, then external, then timer.
    code = 32'h0;
    if (bus.mem_illegal_i)    code = CODE_ILLEGAL;
    else if (bus.mem_ecall_i) code = CODE_ECALL;
    else if (bus.mem_mret_i)  code = CODE_MRET;
    else if (ext_ok)          code = CODE_EXT;
    else if (timer_ok)        code = CODE_TIMER;

    state_d      = state_q;
    excepttype_d = excepttype_q;
    cia_d        = cia_q;
    flush_d      = flush_q;
    mret_d       = mret_q;
    ext_commit   = 1'b0;

    case (state_q)
      IDLE: begin
        excepttype_d = 32'h0;
        flush_d      = 1'b0;
        if (take && code != 32'h0) begin
          state_d      = TRAP;
          excepttype_d = code;
          cia_d        = bus.mem_inst_addr_i;
          flush_d      = 1'b1;
          mret_d       = (code == CODE_MRET);
          ext_commit   = (code == CODE_EXT);
        end
      end
      TRAP: begin
        state_d      = RECOVER;
        excepttype_d = 32'h0;
        flush_d      = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        excepttype_d = 32'h0;
        flush_d      = 1'b0;
      end
    endcase

    // A new edge in the commit cycle keeps the interrupt pending.
    ext_pend_d = ext_rise | (ext_pend_q & ~ext_commit);

    // Redirect target uses CSR values as seen during TRAP itself.
    base   = {bus.mtvec_i[31:2], 2'b00};
    new_pc = 32'h0;
    if (state_q == TRAP) begin
      if (mret_q)
        new_pc = bus.mepc_i;
      else if (excepttype_q[31] && bus.mtvec_i[1:0] == 2'b01)
        new_pc = base + {26'b0, excepttype_q[3:0], 2'b00};
      else
        new_pc = base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      sync_prev_q  <= 1'b0;
      ext_pend_q   <= 1'b0;
      excepttype_q <= 32'h0;
      cia_q        <= 32'h0;
      flush_q      <= 1'b0;
      mret_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      sync_prev_q  <= sync_prev_d;
      ext_pend_q   <= ext_pend_d;
      excepttype_q <= excepttype_d;
      cia_q        <= cia_d;
      flush_q      <= flush_d;
      mret_q       <= mret_d;
    end
  end

  assign bus.excepttype_o        = excepttype_q;
  assign bus.current_inst_addr_o = cia_q;
  assign bus.flush_o             = flush_q;
  assign bus.new_pc_o            = new_pc;

endmodule
